vreg_file_responder: RTL and testbench
======================================

Name: vreg_file_responder

Overview:
- Responder side of the vector-register request/grant/response protocol.
- Owns the vector register storage. Serves read requests from the lane-side execution ports and write requests from the write-buffer ports.
- Per cycle it arbitrates one read and one write using independent round-robin arbiters. Each accepted request is answered with a registered response exactly one cycle later.
- One instance sits beside each single-threaded pipeline.

Parameters:
- NUM_OF_LANES, 4, number of read requestor ports
- NUM_OF_WB, 2, number of write requestor ports
- NUM_OF_VECTOR_REG, 32, number of vector registers
- VECTOR_REG_WIDTH, 64, bits per vector register
- AW, $clog2(NUM_OF_VECTOR_REG), register index width (derived)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- rd_req_vld[NUM_OF_LANES]  in  1 each  read request valid
- rd_req_addr[NUM_OF_LANES]  in  AW each  register index to read
- rd_req_grant[NUM_OF_LANES]  out  1 each  combinational grant; vld&grant = accepted
- rd_rsp_vld[NUM_OF_LANES]  out  1 each  registered read response valid
- rd_rsp_data[NUM_OF_LANES]  out  VECTOR_REG_WIDTH each  read data
- wr_req_vld[NUM_OF_WB]  in  1 each  write request valid
- wr_req_addr[NUM_OF_WB]  in  AW each  register index to write
- wr_req_data[NUM_OF_WB]  in  VECTOR_REG_WIDTH each  write data
- wr_req_grant[NUM_OF_WB]  out  1 each  combinational grant
- wr_rsp_vld[NUM_OF_WB]  out  1 each  write acknowledge
- wr_rsp_data[NUM_OF_WB]  out  VECTOR_REG_WIDTH each  echo of data written

Behaviour:
- Reset (synchronous, active-high):
  - All registers are cleared to 0.
  - rd_ptr and wr_ptr are set to 0.
  - All *_rsp_vld are 0 and all *_rsp_data are 0.
  - Grants are 0 while reset is high.
- Requestor rule: vld, addr and data are held stable until granted. The responder does not check this.
- Read arbiter:
  - Grants the first index i, searching from rd_ptr upward modulo NUM_OF_LANES, with rd_req_vld[i]=1.
  - At most one grant is one-hot per cycle.
  - On a grant, rd_ptr becomes (i+1) mod NUM_OF_LANES. With no request, rd_ptr holds.
- Write arbiter: same rule, using wr_ptr over NUM_OF_WB.
- Grants are combinational from the current vld and ptr. There is no combinational path from rsp to grant.
- Read latency: request granted in cycle N -> rd_rsp_vld[i]=1 and rd_rsp_data[i]=reg[addr] in cycle N+1, for exactly one cycle. Other ports' rsp_vld are 0; their rsp_data holds its last value.
- Write latency: granted in cycle N -> register updated at the end of cycle N. In cycle N+1, wr_rsp_vld[j]=1 and wr_rsp_data[j]=written data, for one cycle.
- Read of an address written in an earlier cycle returns the new value.
- Same-cycle read and write to the same address: see Optional Feature.
- Back-to-back: the same port may be granted on consecutive cycles when it is the only requestor. Throughput is 1 read plus 1 write per cycle.
- Reset asserted mid-operation: responses pending for the next cycle are dropped (rsp_vld=0) and storage is cleared. The arbiter restarts from ptr 0.
- Address width exactly AW; no out-of-range check is needed when NUM_OF_VECTOR_REG is a power of two. For non-power-of-two sizes, indices >= NUM_OF_VECTOR_REG read 0 and writes to them are ignored. Such accesses still receive a grant and a response.

Optional Feature:
- Macro VREG_WR_RD_BYPASS_EN.
- Defined: a read granted in the same cycle as a write to the same address returns the new write data in cycle N+1.
- Not defined: that read returns the old register contents; the write still lands at the end of cycle N.

Test Plan:
- Reset then read: reset 2 cycles; then rd_req_vld[0]=1, addr 5 -> grant[0] same cycle; cycle+1 rd_rsp_vld[0]=1, data 0.
- Write then read: wr port 1 writes addr 3 with 64'hDEAD_BEEF_0123_4567 -> wr_rsp_vld[1]=1 next cycle with echoed data. Lane 2 then reads addr 3 -> data 64'hDEAD_BEEF_0123_4567.
- Round-robin fairness: all 4 lanes request continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each lane receives exactly 2 responses.
- Pointer hold: only lane 3 requests for 3 cycles -> granted each cycle. Then lanes 0 and 3 request together -> lane 0 is granted first (ptr wrapped to 0).
- Same-cycle conflict on addr 7 (old value 0x11, new value 0x22): with VREG_WR_RD_BYPASS_EN the read returns 0x22; without it the read returns 0x11. A subsequent read returns 0x22 in both builds.
- Reset mid-operation: grant a read and a write in cycle N, assert reset in cycle N+1 -> in cycle N+1 all rsp_vld=0. After release, all registers read 0 and the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/vreg_file_responder_if.sv
// Request/grant/response bundle between the lane and write-buffer requestors
// and the vector register file responder.
interface vreg_file_responder_if #(
  parameter int NUM_OF_LANES      = 4,
  parameter int NUM_OF_WB         = 2,
  parameter int NUM_OF_VECTOR_REG = 32,
  parameter int VECTOR_REG_WIDTH  = 64,
  parameter int AW = (NUM_OF_VECTOR_REG > 1) ? $clog2(NUM_OF_VECTOR_REG) : 1
) ();
  logic                        rd_req_vld   [NUM_OF_LANES];
  logic [AW-1:0]               rd_req_addr  [NUM_OF_LANES];
  logic                        rd_req_grant [NUM_OF_LANES];
  logic                        rd_rsp_vld   [NUM_OF_LANES];
  logic [VECTOR_REG_WIDTH-1:0] rd_rsp_data  [NUM_OF_LANES];

  logic                        wr_req_vld   [NUM_OF_WB];
  logic [AW-1:0]               wr_req_addr  [NUM_OF_WB];
  logic [VECTOR_REG_WIDTH-1:0] wr_req_data  [NUM_OF_WB];
  logic                        wr_req_grant [NUM_OF_WB];
  logic                        wr_rsp_vld   [NUM_OF_WB];
  logic [VECTOR_REG_WIDTH-1:0] wr_rsp_data  [NUM_OF_WB];

  modport master (
    output rd_req_vld, rd_req_addr,
    input  rd_req_grant, rd_rsp_vld, rd_rsp_data,
    output wr_req_vld, wr_req_addr, wr_req_data,
    input  wr_req_grant, wr_rsp_vld, wr_rsp_data
  );

  modport slave (
    input  rd_req_vld, rd_req_addr,
    output rd_req_grant, rd_rsp_vld, rd_rsp_data,
    input  wr_req_vld, wr_req_addr, wr_req_data,
    output wr_req_grant, wr_rsp_vld, wr_rsp_data
  );
endinterface

// File: rtl/vreg_file_responder.sv
// Vector register file responder: one round-robin read and one round-robin write per cycle,
// registered responses one cycle later. Define VREG_WR_RD_BYPASS_EN to forward same-cycle write data to reads.
module vreg_file_responder #(
  parameter int NUM_OF_LANES      = 4,
  parameter int NUM_OF_WB         = 2,
  parameter int NUM_OF_VECTOR_REG = 32,
  parameter int VECTOR_REG_WIDTH  = 64,
  parameter int AW = (NUM_OF_VECTOR_REG > 1) ? $clog2(NUM_OF_VECTOR_REG) : 1
) (
  input logic                  clk,
  input logic                  reset,
  vreg_file_responder_if.slave bus
);
  localparam int RPW = (NUM_OF_LANES > 1) ? $clog2(NUM_OF_LANES) : 1;
  localparam int WPW = (NUM_OF_WB > 1) ? $clog2(NUM_OF_WB) : 1;

  logic [RPW-1:0]              rd_ptr_q, rd_ptr_d, rd_idx, rd_cand;
  logic [WPW-1:0]              wr_ptr_q, wr_ptr_d, wr_idx, wr_cand;
  logic                        rd_fire, wr_fire;
  logic                        rd_gnt [NUM_OF_LANES];
  logic                        wr_gnt [NUM_OF_WB];
  logic [AW-1:0]               rd_addr_sel, wr_addr_sel;
  logic [VECTOR_REG_WIDTH-1:0] wr_data_sel, rd_rdata;
  logic                        rd_in_range, wr_in_range;

  logic [VECTOR_REG_WIDTH-1:0] mem_q [NUM_OF_VECTOR_REG];
  logic [VECTOR_REG_WIDTH-1:0] mem_d [NUM_OF_VECTOR_REG];

  logic                        rd_rsp_vld_q  [NUM_OF_LANES];
  logic                        rd_rsp_vld_d  [NUM_OF_LANES];
  logic [VECTOR_REG_WIDTH-1:0] rd_rsp_data_q [NUM_OF_LANES];
  logic [VECTOR_REG_WIDTH-1:0] rd_rsp_data_d [NUM_OF_LANES];
  logic                        wr_rsp_vld_q  [NUM_OF_WB];
  logic                        wr_rsp_vld_d  [NUM_OF_WB];
  logic [VECTOR_REG_WIDTH-1:0] wr_rsp_data_q [NUM_OF_WB];
  logic [VECTOR_REG_WIDTH-1:0] wr_rsp_data_d [NUM_OF_WB];

  // Read arbiter: first valid lane at or above rd_ptr, wrapping.
  always_comb begin
    rd_fire  = 1'b0;
    rd_idx   = '0;
    rd_cand  = '0;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < NUM_OF_LANES; i++) rd_gnt[i] = 1'b0;
    if (!reset) begin
      for (int k = 0; k < NUM_OF_LANES; k++) begin
        rd_cand = RPW'((int'(rd_ptr_q) + k) % NUM_OF_LANES);
        if (!rd_fire && bus.rd_req_vld[rd_cand]) begin
          rd_fire = 1'b1;
          rd_idx  = rd_cand;
        end
      end
    end
    if (rd_fire) begin
      rd_gnt[rd_idx] = 1'b1;
      rd_ptr_d       = RPW'((int'(rd_idx) + 1) % NUM_OF_LANES);
    end
  end

  always_comb begin
    wr_fire  = 1'b0;
    wr_idx   = '0;
    wr_cand  = '0;
    wr_ptr_d = wr_ptr_q;
    for (int j = 0; j < NUM_OF_WB; j++) wr_gnt[j] = 1'b0;
    if (!reset) begin
      for (int k = 0; k < NUM_OF_WB; k++) begin
        wr_cand = WPW'((int'(wr_ptr_q) + k) % NUM_OF_WB);
        if (!wr_fire && bus.wr_req_vld[wr_cand]) begin
          wr_fire = 1'b1;
          wr_idx  = wr_cand;
        end
      end
    end
    if (wr_fire) begin
      wr_gnt[wr_idx] = 1'b1;
      wr_ptr_d       = WPW'((int'(wr_idx) + 1) % NUM_OF_WB);
    end
  end

  always_comb begin
    wr_addr_sel = bus.wr_req_addr[wr_idx];
    wr_data_sel = bus.wr_req_data[wr_idx];
    wr_in_range = int'(wr_addr_sel) < NUM_OF_VECTOR_REG;
    rd_addr_sel = bus.rd_req_addr[rd_idx];
    rd_in_range = int'(rd_addr_sel) < NUM_OF_VECTOR_REG;

    mem_d = mem_q;
    if (wr_fire && wr_in_range) mem_d[wr_addr_sel] = wr_data_sel;

    rd_rdata = rd_in_range ? mem_q[rd_addr_sel] : '0;
`ifdef VREG_WR_RD_BYPASS_EN
    if (wr_fire && rd_in_range && (wr_addr_sel == rd_addr_sel)) rd_rdata = wr_data_sel;
`endif
  end

  always_comb begin
    for (int i = 0; i < NUM_OF_LANES; i++) begin
      rd_rsp_vld_d[i]  = rd_gnt[i];
      rd_rsp_data_d[i] = rd_gnt[i] ? rd_rdata : rd_rsp_data_q[i];
    end
    for (int j = 0; j < NUM_OF_WB; j++) begin
      wr_rsp_vld_d[j]  = wr_gnt[j];
      wr_rsp_data_d[j] = wr_gnt[j] ? wr_data_sel : wr_rsp_data_q[j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int r = 0; r < NUM_OF_VECTOR_REG; r++) mem_q[r] <= '0;
      for (int i = 0; i < NUM_OF_LANES; i++) begin
        rd_rsp_vld_q[i]  <= 1'b0;
        rd_rsp_data_q[i] <= '0;
      end
      for (int j = 0; j < NUM_OF_WB; j++) begin
        wr_rsp_vld_q[j]  <= 1'b0;
        wr_rsp_data_q[j] <= '0;
      end
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      mem_q         <= mem_d;
      rd_rsp_vld_q  <= rd_rsp_vld_d;
      rd_rsp_data_q <= rd_rsp_data_d;
      wr_rsp_vld_q  <= wr_rsp_vld_d;
      wr_rsp_data_q <= wr_rsp_data_d;
    end
  end

  // Responses are masked while reset is high so a pending response is dropped
  // in the very cycle reset is raised, not one cycle later.
  always_comb begin
    for (int i = 0; i < NUM_OF_LANES; i++) begin
      bus.rd_req_grant[i] = rd_gnt[i];
      bus.rd_rsp_vld[i]   = rd_rsp_vld_q[i] & ~reset;
      bus.rd_rsp_data[i]  = reset ? '0 : rd_rsp_data_q[i];
    end
    for (int j = 0; j < NUM_OF_WB; j++) begin
      bus.wr_req_grant[j] = wr_gnt[j];
      bus.wr_rsp_vld[j]   = wr_rsp_vld_q[j] & ~reset;
      bus.wr_rsp_data[j]  = reset ? '0 : wr_rsp_data_q[j];
    end
  end
endmodule

// File: tb/tb_vreg_file_responder.sv
// Directed bench for vreg_file_responder: reset, read/write, round-robin, pointer hold,
// same-cycle conflict (both builds of VREG_WR_RD_BYPASS_EN) and mid-operation reset.
module tb_vreg_file_responder;
  localparam int NL = 4;
  localparam int NW = 2;
  localparam int NR = 32;
  localparam int W  = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   rsp_cnt [NL];
  logic [3:0]   exp_g;
  logic [W-1:0] exp_d;

  always #5 clk = ~clk;

  vreg_file_responder_if #(.NUM_OF_LANES(NL), .NUM_OF_WB(NW), .NUM_OF_VECTOR_REG(NR),
                           .VECTOR_REG_WIDTH(W), .AW(AW)) bus ();

  vreg_file_responder #(.NUM_OF_LANES(NL), .NUM_OF_WB(NW), .NUM_OF_VECTOR_REG(NR),
                        .VECTOR_REG_WIDTH(W), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] rd_gnt_v();
    for (int i = 0; i < NL; i++) rd_gnt_v[i] = bus.rd_req_grant[i];
  endfunction
  function automatic logic [3:0] rd_vld_v();
    for (int i = 0; i < NL; i++) rd_vld_v[i] = bus.rd_rsp_vld[i];
  endfunction
  function automatic logic [1:0] wr_gnt_v();
    for (int j = 0; j < NW; j++) wr_gnt_v[j] = bus.wr_req_grant[j];
  endfunction
  function automatic logic [1:0] wr_vld_v();
    for (int j = 0; j < NW; j++) wr_vld_v[j] = bus.wr_rsp_vld[j];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < NL; i++) bus.rd_req_vld[i] = 1'b0;
    for (int j = 0; j < NW; j++) bus.wr_req_vld[j] = 1'b0;
  endtask

  task automatic rd(input int lane, input logic [AW-1:0] addr);
    bus.rd_req_vld[lane]  = 1'b1;
    bus.rd_req_addr[lane] = addr;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] addr, input logic [W-1:0] data);
    bus.wr_req_vld[port]  = 1'b1;
    bus.wr_req_addr[port] = addr;
    bus.wr_req_data[port] = data;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NL; i++) begin
      bus.rd_req_addr[i] = '0;
      rsp_cnt[i] = 0;
    end
    for (int j = 0; j < NW; j++) begin
      bus.wr_req_addr[j] = '0;
      bus.wr_req_data[j] = '0;
    end
    idle();

    // Reset for two cycles with a request already pending: no grant while in reset.
    rd(0, 5);
    repeat (2) tick();
    chk("reset_rd_gnt", rd_gnt_v(), 4'b0000);
    chk("reset_rd_rsp_vld", rd_vld_v(), 4'b0000);
    chk("reset_wr_rsp_vld", wr_vld_v(), 2'b00);

    reset = 1'b0;
    #1 chk("first_rd_gnt", rd_gnt_v(), 4'b0001);
    tick();
    idle();
    chk("first_rd_rsp_vld", rd_vld_v(), 4'b0001);
    chk("first_rd_rsp_data", bus.rd_rsp_data[0], 64'h0);

    // Write port 1 to addr 3, then lane 2 reads it back (rd_ptr=1, wr_ptr=0).
    wr(1, 3, 64'hDEAD_BEEF_0123_4567);
    #1 chk("wr_gnt", wr_gnt_v(), 2'b10);
    tick();
    idle();
    chk("wr_rsp_vld", wr_vld_v(), 2'b10);
    chk("wr_rsp_data", bus.wr_rsp_data[1], 64'hDEAD_BEEF_0123_4567);
    rd(2, 3);
    #1 chk("rdback_gnt", rd_gnt_v(), 4'b0100);
    tick();
    idle();
    chk("rdback_rsp_vld", rd_vld_v(), 4'b0100);
    chk("rdback_data", bus.rd_rsp_data[2], 64'hDEAD_BEEF_0123_4567);

    // Lane 3 alone for three cycles (rd_ptr starts at 3).
    rd(3, 3);
    for (int c = 0; c < 3; c++) begin
      #1 chk("solo_gnt", rd_gnt_v(), 4'b1000);
      tick();
      chk("solo_rsp_vld", rd_vld_v(), 4'b1000);
      chk("solo_rsp_data", bus.rd_rsp_data[3], 64'hDEAD_BEEF_0123_4567);
    end
    rd(0, 3);
    #1 chk("wrap_gnt", rd_gnt_v(), 4'b0001);
    tick();
    chk("wrap_rsp_vld", rd_vld_v(), 4'b0001);
    chk("wrap_rsp_data", bus.rd_rsp_data[0], 64'hDEAD_BEEF_0123_4567);
    bus.rd_req_vld[0] = 1'b0;
    #1 chk("wrap2_gnt", rd_gnt_v(), 4'b1000);
    tick();

    // All four lanes continuously for 8 cycles from rd_ptr=0.
    for (int i = 0; i < NL; i++) rd(i, AW'(i));
    for (int c = 0; c < 8; c++) begin
      exp_g = 4'b0001 << (c % 4);
      #1 chk("rr_gnt", rd_gnt_v(), exp_g);
      tick();
      chk("rr_rsp_vld", rd_vld_v(), exp_g);
      for (int i = 0; i < NL; i++) if (bus.rd_rsp_vld[i]) rsp_cnt[i]++;
    end
    idle();
    for (int i = 0; i < NL; i++) chk("rr_rsp_count", 64'(rsp_cnt[i]), 64'd2);
    chk("rr_lane3_data", bus.rd_rsp_data[3], 64'hDEAD_BEEF_0123_4567);

    // Same-cycle read/write conflict on addr 7 (wr_ptr=0, rd_ptr=0).
    wr(0, 7, 64'h11);
    #1 chk("pre_wr_gnt", wr_gnt_v(), 2'b01);
    tick();
    idle();
    chk("pre_wr_rsp_data", bus.wr_rsp_data[0], 64'h11);
    wr(1, 7, 64'h22);
    rd(0, 7);
    #1 chk("conf_wr_gnt", wr_gnt_v(), 2'b10);
    chk("conf_rd_gnt", rd_gnt_v(), 4'b0001);
    tick();
    idle();
`ifdef VREG_WR_RD_BYPASS_EN
    exp_d = 64'h22;
`else
    exp_d = 64'h11;
`endif
    chk("conf_rd_data", bus.rd_rsp_data[0], exp_d);
    chk("conf_wr_rsp_data", bus.wr_rsp_data[1], 64'h22);
    rd(1, 7);
    #1 chk("after_conf_gnt", rd_gnt_v(), 4'b0010);
    tick();
    idle();
    chk("after_conf_data", bus.rd_rsp_data[1], 64'h22);

    // Grant a read and a write, then raise reset while their responses are due.
    rd(2, 3);
    wr(0, 3, 64'h55);
    #1 chk("midrst_rd_gnt", rd_gnt_v(), 4'b0100);
    chk("midrst_wr_gnt", wr_gnt_v(), 2'b01);
    tick();
    idle();
    reset = 1'b1;
    #1 chk("midrst_rd_rsp_vld", rd_vld_v(), 4'b0000);
    chk("midrst_wr_rsp_vld", wr_vld_v(), 2'b00);
    chk("midrst_rd_rsp_data", bus.rd_rsp_data[2], 64'h0);
    chk("midrst_wr_rsp_data", bus.wr_rsp_data[0], 64'h0);
    tick();
    reset = 1'b0;

    // Arbiters restart from index 0 and storage reads back cleared.
    rd(1, 3);
    rd(3, 7);
    wr(0, 1, 64'h1);
    wr(1, 2, 64'h2);
    #1 chk("post_rst_rd_gnt", rd_gnt_v(), 4'b0010);
    chk("post_rst_wr_gnt", wr_gnt_v(), 2'b01);
    tick();
    bus.rd_req_vld[1] = 1'b0;
    bus.wr_req_vld[0] = 1'b0;
    chk("post_rst_rsp_vld", rd_vld_v(), 4'b0010);
    chk("post_rst_addr3", bus.rd_rsp_data[1], 64'h0);
    #1 chk("post_rst_rd_gnt2", rd_gnt_v(), 4'b1000);
    tick();
    idle();
    chk("post_rst_addr7", bus.rd_rsp_data[3], 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
